// File: rtl/cpc_ram_pkg.sv
// Shared constants and types for the CPC 512K RAM expansion controller:
// paging-register field layout, configuration codes and the OUT-tracking FSM state.
package cpc_ram_pkg;

   localparam logic [1:0] PAGE_TAG = 2'b11;

   localparam int TAG_MSB  = 7;
   localparam int TAG_LSB  = 6;
   localparam int BANK_LSB = 3;
   localparam int CFG_MSB  = 2;
   localparam int CFG_LSB  = 0;

   localparam logic [2:0] CFG_INT  = 3'd0;
   localparam logic [2:0] CFG_TOP  = 3'd1;
   localparam logic [2:0] CFG_FULL = 3'd2;
   localparam logic [2:0] CFG_TOP3 = 3'd3;
   localparam logic [2:0] CFG_WIN0 = 3'd4;
   localparam logic [2:0] CFG_WIN1 = 3'd5;
   localparam logic [2:0] CFG_WIN2 = 3'd6;
   localparam logic [2:0] CFG_WIN3 = 3'd7;

   typedef enum logic {
      IDLE     = 1'b0,
      WAIT_END = 1'b1
   } ctrl_state_e;

   function automatic logic is_page_write(input logic [7:0] data);
      return data[TAG_MSB:TAG_LSB] == PAGE_TAG;
   endfunction

endpackage

// File: rtl/cpc_ram_map_decode.sv
// Combinational memory map: turns the paging state and live address/strobes
// into the SRAM address high bits, SRAM strobes and the internal-RAM override.
module cpc_ram_map_decode
   import cpc_ram_pkg::*;
#(
   parameter int BANK_BITS = 3
) (
   input  logic [BANK_LSB+BANK_BITS-1:0] page_i,
   input  logic [1:0]                    a_hi_i,
   input  logic                          mreq_b_i,
   input  logic                          wr_b_i,
   input  logic                          ramrd_b_i,
   output logic [2+BANK_BITS-1:0]        ram_adr_hi_o,
   output logic                          ramcs_b_o,
   output logic                          ramwe_b_o,
   output logic                          ramoe_b_o,
   output logic                          ramdis_o
);

   logic [2:0]           cfg_s;
   logic [BANK_BITS-1:0] bank_s;
   logic [1:0]           blk_s;
   logic                 sel_s;

   assign cfg_s  = page_i[CFG_MSB:CFG_LSB];
   assign bank_s = page_i[BANK_LSB+BANK_BITS-1:BANK_LSB];

   // Block selection per configuration; an unmapped access passes A15:14 through
   always_comb begin
      sel_s = 1'b0;
      blk_s = a_hi_i;
      case (cfg_s)
         CFG_INT: begin
            sel_s = 1'b0;
         end
         CFG_TOP, CFG_TOP3: begin
            if (a_hi_i == 2'b11) begin
               sel_s = 1'b1;
               blk_s = 2'b11;
            end else begin
               sel_s = 1'b0;
            end
         end
         CFG_FULL: begin
            sel_s = 1'b1;
         end
         CFG_WIN0, CFG_WIN1, CFG_WIN2, CFG_WIN3: begin
            if (a_hi_i == 2'b01) begin
               sel_s = 1'b1;
               blk_s = cfg_s[1:0];
            end else begin
               sel_s = 1'b0;
            end
         end
         default: begin
            sel_s = 1'b0;
         end
      endcase
   end

   assign ram_adr_hi_o = {bank_s, blk_s};
   assign ramcs_b_o    = ~(sel_s & ~mreq_b_i);
   assign ramdis_o     = ~ramcs_b_o;
   assign ramwe_b_o    = wr_b_i | mreq_b_i | ramcs_b_o;
   assign ramoe_b_o    = ramrd_b_i | ramcs_b_o;

endmodule

// File: rtl/cpc_512k_ram_ctrl.sv
// CPC 512K RAM expansion responder: synchronises the I/O strobes, commits one
// paging-register write per qualifying OUT, and drives the SRAM via the map decoder.
module cpc_512k_ram_ctrl
   import cpc_ram_pkg::*;
#(
   parameter int BANK_BITS   = 3,
   parameter int SYNC_STAGES = 1
) (
   input  logic                   CLK,
   input  logic                   RESET,
   input  logic [15:0]            A,
   input  logic [7:0]             D,
   input  logic                   MREQ_B,
   input  logic                   IOREQ_B,
   input  logic                   WR_B,
   input  logic                   RAMRD_B,
   output logic [2+BANK_BITS-1:0] ram_adr_hi,
   output logic                   ramcs_b,
   output logic                   ramwe_b,
   output logic                   ramoe_b,
   output logic                   RAMDIS,
   output logic [7:0]             paging_q
);

   localparam int              SW        = 11;
   localparam logic [SW-1:0]   SYNC_IDLE = 11'b110_0000_0000;

   logic [SW-1:0] sync_d [SYNC_STAGES];
   logic [SW-1:0] sync_q [SYNC_STAGES];
   logic [SW-1:0] smp_s;
   logic          qual_s;
   ctrl_state_e   state_d, state_q;
   logic [7:0]    paging_d;
   logic          unused_a_s;

   assign unused_a_s = ^A[13:0];

   // Sample chain for {IOREQ_B, WR_B, A15, D}
   always_comb begin
      sync_d[0] = {IOREQ_B, WR_B, A[15], D};
      for (int i = 1; i < SYNC_STAGES; i++) begin
         sync_d[i] = sync_q[i-1];
      end
   end

   // Synchroniser registers; reset to an idle bus so no stale OUT is seen
   always_ff @(posedge CLK) begin
      if (RESET) begin
         for (int i = 0; i < SYNC_STAGES; i++) begin
            sync_q[i] <= SYNC_IDLE;
         end
      end else begin
         for (int i = 0; i < SYNC_STAGES; i++) begin
            sync_q[i] <= sync_d[i];
         end
      end
   end

   assign smp_s  = sync_q[SYNC_STAGES-1];
   assign qual_s = ~smp_s[10] & ~smp_s[9] & ~smp_s[8] & is_page_write(smp_s[7:0]);

   // One commit per I/O cycle: WAIT_END holds off until IOREQ_B is released
   always_comb begin
      state_d  = state_q;
      paging_d = paging_q;
      case (state_q)
         IDLE: begin
            if (qual_s) begin
               paging_d = smp_s[7:0];
               state_d  = WAIT_END;
            end else begin
               state_d  = IDLE;
            end
         end
         WAIT_END: begin
            if (smp_s[10]) begin
               state_d = IDLE;
            end else begin
               state_d = WAIT_END;
            end
         end
         default: begin
            state_d = IDLE;
         end
      endcase
   end

   // FSM state and paging register
   always_ff @(posedge CLK) begin
      if (RESET) begin
         state_q  <= IDLE;
         paging_q <= 8'h00;
      end else begin
         state_q  <= state_d;
         paging_q <= paging_d;
      end
   end

   cpc_ram_map_decode #(
      .BANK_BITS (BANK_BITS)
   ) u_map (
      .page_i       (paging_q[BANK_LSB+BANK_BITS-1:0]),
      .a_hi_i       (A[15:14]),
      .mreq_b_i     (MREQ_B),
      .wr_b_i       (WR_B),
      .ramrd_b_i    (RAMRD_B),
      .ram_adr_hi_o (ram_adr_hi),
      .ramcs_b_o    (ramcs_b),
      .ramwe_b_o    (ramwe_b),
      .ramoe_b_o    (ramoe_b),
      .ramdis_o     (RAMDIS)
   );

endmodule

// File: tb/tb_cpc_512k_ram_ctrl.sv
// Self-checking bench for cpc_512k_ram_ctrl: a table of OUT/memory vectors
// followed by hand-written sequences for latency, held strobes and reset.
module tb_cpc_512k_ram_ctrl;

   logic        CLK = 1'b0;
   logic        RESET;
   logic [15:0] A;
   logic [7:0]  D;
   logic        MREQ_B, IOREQ_B, WR_B, RAMRD_B;
   logic [4:0]  ram_adr_hi;
   logic        ramcs_b, ramwe_b, ramoe_b, RAMDIS;
   logic [7:0]  paging_q;

   int errors = 0;
   int checks = 0;

   cpc_512k_ram_ctrl #(.BANK_BITS(3), .SYNC_STAGES(1)) dut (
      .CLK        (CLK),
      .RESET      (RESET),
      .A          (A),
      .D          (D),
      .MREQ_B     (MREQ_B),
      .IOREQ_B    (IOREQ_B),
      .WR_B       (WR_B),
      .RAMRD_B    (RAMRD_B),
      .ram_adr_hi (ram_adr_hi),
      .ramcs_b    (ramcs_b),
      .ramwe_b    (ramwe_b),
      .ramoe_b    (ramoe_b),
      .RAMDIS     (RAMDIS),
      .paging_q   (paging_q)
   );

   always #5 CLK = ~CLK;

   typedef struct {
      bit          is_out;
      logic [15:0] a;
      logic [7:0]  d;
      logic        mreq_b;
      logic        wr_b;
      logic        rd_b;
      logic [7:0]  exp_pg;
      logic [4:0]  exp_adr;
      logic        exp_cs;
      logic        exp_we;
      logic        exp_oe;
      logic        exp_dis;
   } vec_t;

   localparam int NV = 23;
   vec_t vecs [NV];

   function automatic vec_t mk(input bit is_out, input logic [15:0] a, input logic [7:0] d,
                               input logic mreq_b, input logic wr_b, input logic rd_b,
                               input logic [7:0] pg, input logic [4:0] adr,
                               input logic cs, input logic we, input logic oe, input logic dis);
      vec_t v;
      v.is_out = is_out; v.a = a; v.d = d;
      v.mreq_b = mreq_b; v.wr_b = wr_b; v.rd_b = rd_b;
      v.exp_pg = pg; v.exp_adr = adr;
      v.exp_cs = cs; v.exp_we = we; v.exp_oe = oe; v.exp_dis = dis;
      return v;
   endfunction

   task automatic check(input string nm, input logic [7:0] act, input logic [7:0] exp);
      checks++;
      if (act !== exp) begin
         errors++;
         $display("FAIL %s: got %h expected %h", nm, act, exp);
      end
   endtask

   task automatic bus_idle();
      A = 16'h0000; D = 8'h00;
      MREQ_B = 1'b1; IOREQ_B = 1'b1; WR_B = 1'b1; RAMRD_B = 1'b1;
   endtask

   task automatic do_out(input logic [15:0] a, input logic [7:0] d);
      @(negedge CLK);
      A = a; D = d; MREQ_B = 1'b1; RAMRD_B = 1'b1; IOREQ_B = 1'b0; WR_B = 1'b0;
      repeat (4) @(negedge CLK);
      IOREQ_B = 1'b1; WR_B = 1'b1;
      repeat (3) @(negedge CLK);
   endtask

   initial begin
      //               out  A        D      mreq  wr    rd    pg     adr       cs    we    oe    dis
      vecs[0]  = mk(1'b0, 16'h0000, 8'h00, 1'b1, 1'b1, 1'b1, 8'h00, 5'b00000, 1'b1, 1'b1, 1'b1, 1'b0);
      vecs[1]  = mk(1'b0, 16'h4000, 8'h00, 1'b0, 1'b1, 1'b0, 8'h00, 5'b00001, 1'b1, 1'b1, 1'b1, 1'b0);
      vecs[2]  = mk(1'b1, 16'h7FFF, 8'hEE, 1'b1, 1'b1, 1'b1, 8'hEE, 5'b00000, 1'b1, 1'b1, 1'b1, 1'b0);
      vecs[3]  = mk(1'b0, 16'h4000, 8'h5A, 1'b0, 1'b0, 1'b1, 8'hEE, 5'b10110, 1'b0, 1'b0, 1'b1, 1'b1);
      vecs[4]  = mk(1'b0, 16'h8000, 8'h00, 1'b0, 1'b1, 1'b0, 8'hEE, 5'b10110, 1'b1, 1'b1, 1'b1, 1'b0);
      vecs[5]  = mk(1'b0, 16'h4000, 8'h00, 1'b0, 1'b1, 1'b0, 8'hEE, 5'b10110, 1'b0, 1'b1, 1'b0, 1'b1);
      vecs[6]  = mk(1'b1, 16'h7FFF, 8'hD2, 1'b1, 1'b1, 1'b1, 8'hD2, 5'b00000, 1'b1, 1'b1, 1'b1, 1'b0);
      vecs[7]  = mk(1'b0, 16'h0000, 8'h00, 1'b0, 1'b1, 1'b0, 8'hD2, 5'b01000, 1'b0, 1'b1, 1'b0, 1'b1);
      vecs[8]  = mk(1'b0, 16'h4000, 8'h00, 1'b0, 1'b1, 1'b0, 8'hD2, 5'b01001, 1'b0, 1'b1, 1'b0, 1'b1);
      vecs[9]  = mk(1'b0, 16'h8000, 8'h00, 1'b0, 1'b1, 1'b0, 8'hD2, 5'b01010, 1'b0, 1'b1, 1'b0, 1'b1);
      vecs[10] = mk(1'b0, 16'hC000, 8'h00, 1'b0, 1'b1, 1'b0, 8'hD2, 5'b01011, 1'b0, 1'b1, 1'b0, 1'b1);
      vecs[11] = mk(1'b0, 16'hC000, 8'h00, 1'b0, 1'b1, 1'b1, 8'hD2, 5'b01011, 1'b0, 1'b1, 1'b1, 1'b1);
      vecs[12] = mk(1'b0, 16'hC000, 8'h00, 1'b1, 1'b1, 1'b0, 8'hD2, 5'b01011, 1'b1, 1'b1, 1'b1, 1'b0);
      vecs[13] = mk(1'b1, 16'h7FFF, 8'h4E, 1'b1, 1'b1, 1'b1, 8'hD2, 5'b00000, 1'b1, 1'b1, 1'b1, 1'b0);
      vecs[14] = mk(1'b1, 16'hFFFF, 8'hEE, 1'b1, 1'b1, 1'b1, 8'hD2, 5'b00000, 1'b1, 1'b1, 1'b1, 1'b0);
      vecs[15] = mk(1'b1, 16'h7FFF, 8'hE1, 1'b1, 1'b1, 1'b1, 8'hE1, 5'b00000, 1'b1, 1'b1, 1'b1, 1'b0);
      vecs[16] = mk(1'b0, 16'hC000, 8'h00, 1'b0, 1'b1, 1'b0, 8'hE1, 5'b10011, 1'b0, 1'b1, 1'b0, 1'b1);
      vecs[17] = mk(1'b0, 16'h4000, 8'h00, 1'b0, 1'b1, 1'b0, 8'hE1, 5'b10001, 1'b1, 1'b1, 1'b1, 1'b0);
      vecs[18] = mk(1'b1, 16'h7FFF, 8'hFB, 1'b1, 1'b1, 1'b1, 8'hFB, 5'b00000, 1'b1, 1'b1, 1'b1, 1'b0);
      vecs[19] = mk(1'b0, 16'hC000, 8'h00, 1'b0, 1'b0, 1'b1, 8'hFB, 5'b11111, 1'b0, 1'b0, 1'b1, 1'b1);
      vecs[20] = mk(1'b0, 16'h8000, 8'h00, 1'b0, 1'b1, 1'b0, 8'hFB, 5'b11110, 1'b1, 1'b1, 1'b1, 1'b0);
      vecs[21] = mk(1'b1, 16'h3FFF, 8'hC0, 1'b1, 1'b1, 1'b1, 8'hC0, 5'b00000, 1'b1, 1'b1, 1'b1, 1'b0);
      vecs[22] = mk(1'b0, 16'hC000, 8'h00, 1'b0, 1'b1, 1'b0, 8'hC0, 5'b00011, 1'b1, 1'b1, 1'b1, 1'b0);

      RESET = 1'b1;
      bus_idle();
      repeat (3) @(negedge CLK);
      RESET = 1'b0;

      for (int i = 0; i < NV; i++) begin
         if (vecs[i].is_out) begin
            do_out(vecs[i].a, vecs[i].d);
            check($sformatf("vec%0d paging_q", i), paging_q, vecs[i].exp_pg);
         end else begin
            @(negedge CLK);
            A = vecs[i].a; D = vecs[i].d; IOREQ_B = 1'b1;
            MREQ_B = vecs[i].mreq_b; WR_B = vecs[i].wr_b; RAMRD_B = vecs[i].rd_b;
            #1;
            check($sformatf("vec%0d paging_q", i), paging_q, vecs[i].exp_pg);
            check($sformatf("vec%0d ram_adr_hi", i), {3'b000, ram_adr_hi}, {3'b000, vecs[i].exp_adr});
            check($sformatf("vec%0d ramcs_b", i), {7'd0, ramcs_b}, {7'd0, vecs[i].exp_cs});
            check($sformatf("vec%0d ramwe_b", i), {7'd0, ramwe_b}, {7'd0, vecs[i].exp_we});
            check($sformatf("vec%0d ramoe_b", i), {7'd0, ramoe_b}, {7'd0, vecs[i].exp_oe});
            check($sformatf("vec%0d RAMDIS", i), {7'd0, RAMDIS}, {7'd0, vecs[i].exp_dis});
         end
      end

      // Interrupt acknowledge: MREQ_B and IOREQ_B low together, WR_B high
      @(negedge CLK);
      bus_idle();
      A = 16'h0038; D = 8'hC5; MREQ_B = 1'b0; IOREQ_B = 1'b0;
      repeat (5) @(negedge CLK);
      check("intack no commit", paging_q, 8'hC0);
      bus_idle();
      repeat (3) @(negedge CLK);

      // Commit latency: second rising edge after pins qualify
      A = 16'h7FFF; D = 8'hC3; IOREQ_B = 1'b0; WR_B = 1'b0;
      @(posedge CLK); #1;
      check("latency edge1", paging_q, 8'hC0);
      @(posedge CLK); #1;
      check("latency edge2", paging_q, 8'hC3);
      @(negedge CLK);
      IOREQ_B = 1'b1; WR_B = 1'b1;
      repeat (3) @(negedge CLK);

      // Strobes held 10 cycles with data changing: single commit of first value
      A = 16'h7FFF; D = 8'hC1; IOREQ_B = 1'b0; WR_B = 1'b0;
      repeat (3) @(negedge CLK);
      D = 8'hC2;
      repeat (7) @(negedge CLK);
      check("held strobes", paging_q, 8'hC1);
      IOREQ_B = 1'b1; WR_B = 1'b1;
      repeat (3) @(negedge CLK);
      check("held after release", paging_q, 8'hC1);

      // Reset mid-OUT with strobes still low after release
      A = 16'h7FFF; D = 8'hC4; IOREQ_B = 1'b0; WR_B = 1'b0;
      repeat (3) @(negedge CLK);
      check("pre-reset commit", paging_q, 8'hC4);
      RESET = 1'b1;
      @(negedge CLK);
      check("in reset paging", paging_q, 8'h00);
      check("in reset ramcs_b", {7'd0, ramcs_b}, 8'h01);
      RESET = 1'b0;
      @(posedge CLK); #1;
      check("post-reset edge1", paging_q, 8'h00);
      @(posedge CLK); #1;
      check("post-reset edge2", paging_q, 8'hC4);
      @(negedge CLK);
      D = 8'hC7;
      repeat (5) @(negedge CLK);
      check("no second commit", paging_q, 8'hC4);
      IOREQ_B = 1'b1; WR_B = 1'b1;
      repeat (3) @(negedge CLK);
      check("reset seq final", paging_q, 8'hC4);

      $display("Result: errors=%0d of %0d checks", errors, checks);
      $finish;
   end

endmodule

// File: doc/cpc_512k_ram_ctrl.md
Name: cpc_512k_ram_ctrl

Overview:
Synchronous RTL responder for the CPC 512K RAM expansion. It is the target-side counterpart of the Z80 bus cycles (memory read/write, OUT) driven at the expansion connector. It decodes OUT writes to the paging port into a paging register. From the live address and the paging register it maps each memory cycle onto the external 512K x 8 SRAM, and asserts RAMDIS so that the internal RAM is overridden. It sits between the expansion connector and the SRAM.

Parameters:
BANK_BITS, 3, number of paging data bits D[3+BANK_BITS-1:3] used as the 64K bank select (3 gives 8 banks / 512K)
SYNC_STAGES, 1, register stages on IOREQ_B/WR_B/A15/D before FSM qualification (1 or 2)

Ports:
CLK  input  1  system clock, at least 4 MHz, all state updates on the rising edge
RESET  input  1  synchronous active-high reset
A  input  16  Z80 address bus
D  input  8  Z80 data bus (input only; this block never drives D)
MREQ_B  input  1  memory request, active low
IOREQ_B  input  1  I/O request, active low
WR_B  input  1  write strobe, active low
RAMRD_B  input  1  connector RAM read strobe, active low
ram_adr_hi  output  2+BANK_BITS  SRAM address bits above A13: {bank, block}
ramcs_b  output  1  SRAM chip select, active low
ramwe_b  output  1  SRAM write enable, active low
ramoe_b  output  1  SRAM output enable, active low
RAMDIS  output  1  internal RAM disable, active high
paging_q  output  8  paging register contents (debug/visibility)

Behaviour:
- Paging register: fields D[7:6] tag, D[5:3] bank, D[2:0] config. Reset value 8'h00 (config 0, bank 0).
- Qualifying OUT, evaluated on the synchronised samples: IOREQ_B=0, WR_B=0, A15=0, D[7:6]=2'b11. A[14:0] is don't-care. Writes with D[7:6]≠11 are gate-array writes and are ignored.
- FSM states: IDLE and WAIT_END.
  - IDLE: on a qualifying sample, load the paging register with the sampled D and go to WAIT_END.
  - WAIT_END: stay until the sampled IOREQ_B=1, then return to IDLE.
  - Result: exactly one commit per I/O cycle, however long the strobes stay asserted. A data change while in WAIT_END has no effect.
- Latency: the register updates on the (SYNC_STAGES+1)th rising CLK after the pins satisfy the condition.
- Block select, combinational from paging_q and the live A[15:14]:
  - cfg0: no external selection.
  - cfg1: A15:14=11 → block 3.
  - cfg2: any address → block A15:14.
  - cfg3: A15:14=11 → block 3.
  - cfg4-7: A15:14=01 → block cfg-4.
- ram_adr_hi = {bank, block}. When unselected, block = A15:14.
- sel is high when an external block is mapped per the table above for the live A[15:14] and the current config.
- ramcs_b = !(sel & !MREQ_B).
- RAMDIS = !ramcs_b.
- ramwe_b = WR_B | MREQ_B | ramcs_b.
- ramoe_b = RAMRD_B | ramcs_b.
- Memory-side outputs are combinational and have no CLK latency. A paging change takes effect for the first memory cycle after the commit edge.
- Reset asserted mid-cycle: the register clears and the FSM enters IDLE. If a qualifying OUT is still present after RESET falls, it commits once.
- Reset values: ramcs_b=1, ramwe_b=1, ramoe_b=1, RAMDIS=0 (whenever MREQ_B=1 or cfg0). ram_adr_hi = {0, A15:14}.
- Simultaneous MREQ_B=0 and IOREQ_B=0 (interrupt acknowledge) never commits, because WR_B stays high.

Decomposition:
- Package cpc_ram_pkg holds:
  - paging tag constant 2'b11
  - field bit positions
  - config codes CFG_INT, CFG_TOP, CFG_FULL, CFG_TOP3, CFG_WIN0..3
  - FSM state type {IDLE, WAIT_END}
- Sub-module cpc_ram_map_decode is purely combinational. It maps {paging_q, A[15:14], MREQ_B, WR_B, RAMRD_B} to {ram_adr_hi, ramcs_b, ramwe_b, ramoe_b, RAMDIS}.
- The top level owns the synchronisers, the FSM and the paging register.

Test Plan:
- Reset, then idle bus → paging_q=00, ramcs_b=1, RAMDIS=0; memory read at &4000 leaves ramcs_b=1.
- OUT &7FFF,&EE (bank 5, cfg6); memory write &4000 with D=&5A → ramcs_b=0, ramwe_b=0, ram_adr_hi=10110, RAMDIS=1. A read at &8000 keeps ramcs_b=1.
- OUT &7FFF,&D2 (bank 2, cfg2); reads at &0000/&4000/&8000/&C000 → ram_adr_hi 01000/01001/01010/01011, ramoe_b follows RAMRD_B.
- OUT &7FFF,&4E (tag 01) and OUT &FFFF,&EE (A15=1) → paging_q unchanged.
- OUT held asserted 10 cycles while D changes &C1→&C2 → single commit, paging_q=&C1.
- RESET pulsed mid-OUT of &C4 with strobes still low after release → paging_q=&C4 one commit later; no second commit before IOREQ_B rises.
